// File: rtl/i2s_pkg.sv
// Shared types and sizing helpers for the stereo I2S transmitter.
package i2s_pkg;

    typedef enum logic {
        I2S_PHILIPS   = 1'b0,
        I2S_LEFT_JUST = 1'b1
    } i2s_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } i2s_state_t;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_SLOT_W     = 32;
    localparam int unsigned DEF_CLK_DIV    = 4;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    // Bits in one stereo frame (left slot + right slot).
    function automatic int unsigned frame_bits(input int unsigned slot_w);
        return 2 * slot_w;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2s_tx_stereo_if.sv
// Sample-pair stream from the decoder buffer into the I2S transmitter.
interface i2s_tx_stereo_if
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_left;
    logic [DATA_W-1:0] s_right;

    modport master (
        output s_valid,
        output s_left,
        output s_right,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_left,
        input  s_right,
        output s_ready
    );

endinterface

// File: rtl/i2s_frame_fifo.sv
// Synchronous frame FIFO with registered level and registered ready.
module i2s_frame_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;
    logic [LVL_W-1:0] level_nxt;

    assign empty_c   = (level == '0);
    assign do_push_c = push && ready;
    assign do_pop_c  = pop && !empty_c;
    assign head_c    = mem[rd_ptr];

    // Simultaneous push and pop leave the level unchanged.
    always_comb begin
        level_nxt = level;
        if (do_push_c && !do_pop_c) begin
            level_nxt = level + LVL_W'(1);
        end else if (!do_push_c && do_pop_c) begin
            level_nxt = level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // ready stays low through reset and rises on the first clock after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_nxt;
            ready <= (level_nxt != LVL_W'(DEPTH));
        end
    end

endmodule

// File: rtl/i2s_tx_stereo.sv
// Stereo I2S transmitter: frame FIFO, run/drain FSM, SCLK divider and frame serializer.
module i2s_tx_stereo
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned SLOT_W     = DEF_SLOT_W,
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          mode,
    i2s_tx_stereo_if.slave                s,
    input  logic                          clr_underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic                          sclk,
    output logic                          ws,
    output logic                          sd
);

    localparam int unsigned FRAME_W = frame_bits(SLOT_W);
    localparam int unsigned BIT_W   = cnt_w(FRAME_W);
    localparam int unsigned DIV_W   = cnt_w(CLK_DIV);
    localparam int unsigned HALF    = CLK_DIV / 2;
    localparam int unsigned PAD_W   = SLOT_W - DATA_W;
    localparam int unsigned PAIR_W  = 2 * DATA_W;

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_RUN   = 2'(RUN);
    localparam logic [1:0] S_DRAIN = 2'(DRAIN);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

    logic [1:0]         state_q, state_nxt;
    logic [DIV_W-1:0]   div_q, div_nxt;
    logic [BIT_W-1:0]   bit_q, bit_nxt;
    logic [FRAME_W-1:0] shreg_q, shreg_nxt;
    i2s_mode_t          mode_q, mode_nxt;
    logic               underrun_nxt;
    logic               sclk_nxt, ws_nxt, sd_nxt;
    logic               idle_nxt;
    logic               frame_start_c;
    logic               pop_c;
    logic               fifo_empty_c;
    logic               fifo_ready;
    logic [PAIR_W-1:0]  fifo_head_c;
    logic [SLOT_W-1:0]  slot_l_c, slot_r_c;

    i2s_frame_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (s.s_valid),
        .wdata   ({s.s_left, s.s_right}),
        .pop     (pop_c),
        .head_c  (fifo_head_c),
        .empty_c (fifo_empty_c),
        .level   (fifo_level),
        .ready   (fifo_ready)
    );

    assign s.s_ready = fifo_ready;

    // Samples sit MSB-aligned in their slot with zero padding below.
    assign slot_l_c = SLOT_W'(fifo_head_c[PAIR_W-1 -: DATA_W]) << PAD_W;
    assign slot_r_c = SLOT_W'(fifo_head_c[DATA_W-1:0]) << PAD_W;

    // Next-state: counters advance per clk; a frame boundary decides run vs. stop.
    always_comb begin
        state_nxt     = state_q;
        div_nxt       = div_q;
        bit_nxt       = bit_q;
        shreg_nxt     = shreg_q;
        mode_nxt      = mode_q;
        underrun_nxt  = underrun && !clr_underrun;
        frame_start_c = 1'b0;
        pop_c         = 1'b0;

        case (state_q)
            S_IDLE: begin
                div_nxt   = '0;
                bit_nxt   = '0;
                shreg_nxt = '0;
                if (en) begin
                    state_nxt     = S_RUN;
                    frame_start_c = 1'b1;
                end
            end
            S_RUN, S_DRAIN: begin
                if (div_q == DIV_LAST && bit_q == BIT_LAST) begin
                    if (en) begin
                        state_nxt     = S_RUN;
                        frame_start_c = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        div_nxt   = '0;
                        bit_nxt   = '0;
                        shreg_nxt = '0;
                    end
                end else begin
                    if (div_q == DIV_LAST) begin
                        div_nxt   = '0;
                        bit_nxt   = bit_q + BIT_W'(1);
                        shreg_nxt = shreg_q << 1;
                    end else begin
                        div_nxt = div_q + DIV_W'(1);
                    end
                    state_nxt = en ? S_RUN : S_DRAIN;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                div_nxt   = '0;
                bit_nxt   = '0;
                shreg_nxt = '0;
            end
        endcase

        if (frame_start_c) begin
            div_nxt   = '0;
            bit_nxt   = '0;
            mode_nxt  = i2s_mode_t'(mode);
            pop_c     = !fifo_empty_c;
            shreg_nxt = fifo_empty_c ? '0 : {slot_l_c, slot_r_c};
            if (fifo_empty_c) begin
                underrun_nxt = 1'b1;
            end
        end
    end

    // Pin values track the next counter state so they appear with it; Philips lags by one bit.
    always_comb begin
        idle_nxt = (state_nxt == S_IDLE);
        sclk_nxt = !idle_nxt && (div_nxt >= DIV_W'(HALF));
        ws_nxt   = !idle_nxt && (bit_nxt >= BIT_W'(SLOT_W));
        sd_nxt   = sd;
        if (idle_nxt) begin
            sd_nxt = 1'b0;
        end else if (div_nxt == '0) begin
            sd_nxt = (mode_nxt == I2S_LEFT_JUST) ? shreg_nxt[FRAME_W-1] : shreg_q[FRAME_W-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            mode_q   <= I2S_PHILIPS;
            underrun <= 1'b0;
            sclk     <= 1'b0;
            ws       <= 1'b0;
            sd       <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            div_q    <= div_nxt;
            bit_q    <= bit_nxt;
            shreg_q  <= shreg_nxt;
            mode_q   <= mode_nxt;
            underrun <= underrun_nxt;
            sclk     <= sclk_nxt;
            ws       <= ws_nxt;
            sd       <= sd_nxt;
        end
    end

endmodule

// File: tb/tb_i2s_tx_stereo.sv
// Bench for i2s_tx_stereo: cycle-index reference model, per-cycle compare, directed scenarios.
module tb_i2s_tx_stereo;

    localparam int DATA_W     = 16;
    localparam int SLOT_W     = 16;
    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME_W    = 2 * SLOT_W;
    localparam int FCYC       = FRAME_W * CLK_DIV;
    localparam int CAP_N      = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic mode = 1'b1;
    logic clr_underrun = 1'b0;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic underrun, sclk, ws, sd;

    i2s_tx_stereo_if #(.DATA_W(DATA_W)) s_if ();

    i2s_tx_stereo #(
        .DATA_W(DATA_W), .SLOT_W(SLOT_W), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s_if),
        .clr_underrun(clr_underrun), .fifo_level(fifo_level), .underrun(underrun),
        .sclk(sclk), .ws(ws), .sd(sd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: frame position as a clk index, FIFO as a queue.
    logic [2*DATA_W-1:0] m_q[$];
    bit                  m_active;
    int                  m_t;
    logic [FRAME_W-1:0]  m_frame;
    logic                m_prev_last, m_lj, m_under, m_rdy;
    bit                  m_start, m_was_active, m_accept;
    logic [2*DATA_W-1:0] m_pr;

    function automatic logic [FRAME_W-1:0] frame_of(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        logic [FRAME_W-1:0] fl, fr;
        fl = FRAME_W'(l);
        fr = FRAME_W'(r);
        return (fl << (FRAME_W - DATA_W)) | (fr << (SLOT_W - DATA_W));
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_active = 1'b0;
            m_t = 0;
            m_frame = '0;
            m_prev_last = 1'b0;
            m_lj = 1'b0;
            m_under = 1'b0;
            m_rdy = 1'b0;
        end else begin
            m_accept = s_if.s_valid && m_rdy;
            m_was_active = m_active;
            m_start = 1'b0;
            if (!m_active) begin
                if (en) begin
                    m_active = 1'b1;
                    m_start = 1'b1;
                end
            end else if (m_t == FCYC - 1) begin
                if (en) m_start = 1'b1;
                else m_active = 1'b0;
            end else begin
                m_t++;
            end
            m_under = m_under && !clr_underrun;
            if (m_start) begin
                m_prev_last = m_was_active ? m_frame[0] : 1'b0;
                m_t = 0;
                m_lj = mode;
                if (m_q.size() > 0) begin
                    m_pr = m_q.pop_front();
                    m_frame = frame_of(m_pr[2*DATA_W-1:DATA_W], m_pr[DATA_W-1:0]);
                end else begin
                    m_frame = '0;
                    m_under = 1'b1;
                end
            end
            if (m_accept) m_q.push_back({s_if.s_left, s_if.s_right});
            m_rdy = (m_q.size() < FIFO_DEPTH);
        end
    end

    int   e_bit, e_ph;
    logic e_sclk, e_ws, e_sd;

    always @(negedge clk) begin
        if (chk_on) begin
            e_sclk = 1'b0;
            e_ws = 1'b0;
            e_sd = 1'b0;
            if (m_active) begin
                e_bit = m_t / CLK_DIV;
                e_ph = m_t % CLK_DIV;
                e_sclk = (e_ph >= CLK_DIV / 2);
                e_ws = (e_bit >= SLOT_W);
                if (m_lj) e_sd = m_frame[FRAME_W - 1 - e_bit];
                else e_sd = (e_bit == 0) ? m_prev_last : m_frame[FRAME_W - e_bit];
            end
            chk("sclk", 32'(sclk), 32'(e_sclk));
            chk("ws", 32'(ws), 32'(e_ws));
            chk("sd", 32'(sd), 32'(e_sd));
            chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
            chk("s_ready", 32'(s_if.s_ready), 32'(m_rdy));
            chk("underrun", 32'(underrun), 32'(m_under));
        end
    end

    // Bits as a DAC would see them on SCLK rising edges.
    logic cap_bits [CAP_N];
    logic cap_ws   [CAP_N];
    int   n_cap = 0;
    logic sclk_prev = 1'b0;

    always @(negedge clk) begin
        if (sclk && !sclk_prev && n_cap < CAP_N) begin
            cap_bits[n_cap] = sd;
            cap_ws[n_cap] = ws;
            n_cap++;
        end
        sclk_prev = sclk;
    end

    function automatic logic [31:0] word_at(input int base, input bit use_ws);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32; i++) w = {w[30:0], use_ws ? cap_ws[base + i] : cap_bits[base + i]};
        return w;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        int b;
        b = 0;
        s_if.s_valid = 1'b1;
        s_if.s_left = l;
        s_if.s_right = r;
        while (!s_if.s_ready && b < 400) begin
            @(negedge clk);
            b++;
        end
        if (!s_if.s_ready) chk("push_timeout", 32'(s_if.s_ready), 32'd1);
        @(negedge clk);
        s_if.s_valid = 1'b0;
    endtask

    logic [DATA_W-1:0] tl [5] = '{16'h1234, 16'hFEDC, 16'h8001, 16'h7FFE, 16'hC3A5};
    logic [DATA_W-1:0] tr [5] = '{16'h5678, 16'h0BA9, 16'h0001, 16'h8000, 16'h5A3C};

    initial begin
        int base, b;
        s_if.s_valid = 1'b0;
        s_if.s_left = '0;
        s_if.s_right = '0;
        #2;
        rst = 1'b0;
        chk_on = 1'b1;
        wait_cyc(3);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_ws", 32'(ws), 32'd0);
        chk("rst_sd", 32'(sd), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_ready", 32'(s_if.s_ready), 32'd0);
        rst = 1'b1;
        wait_cyc(1);
        chk("ready_after_rst", 32'(s_if.s_ready), 32'd1);

        // Left-justified frame; en drop and mode toggle mid-frame must not disturb it.
        push_pair(16'hA5F0, 16'h0F0F);
        chk("lj_level", 32'(fifo_level), 32'd1);
        base = n_cap;
        en = 1'b1;
        wait_cyc(40);
        en = 1'b0;
        mode = 1'b0;
        wait_cyc(100);
        chk("lj_nbits", 32'(n_cap - base), 32'd32);
        chk("lj_data", word_at(base, 1'b0), 32'hA5F00F0F);
        chk("lj_ws", word_at(base, 1'b1), 32'h0000FFFF);
        chk("lj_idle_sclk", 32'(sclk), 32'd0);
        chk("lj_underrun", 32'(underrun), 32'd0);

        // Philips: same pair, one SCLK later; bit 0 after idle carries 0.
        push_pair(16'hA5F0, 16'h0F0F);
        base = n_cap;
        en = 1'b1;
        wait_cyc(1);
        chk("ph_b0_sd", 32'(sd), 32'd0);
        chk("ph_b0_ws", 32'(ws), 32'd0);
        chk("ph_b0_sclk", 32'(sclk), 32'd0);
        wait_cyc(10);
        en = 1'b0;
        wait_cyc(130);
        chk("ph_data", word_at(base, 1'b0), 32'h52F80787);

        // Underrun on an empty FIFO, sticky until cleared.
        mode = 1'b1;
        base = n_cap;
        en = 1'b1;
        wait_cyc(2);
        chk("ur_set", 32'(underrun), 32'd1);
        wait_cyc(10);
        en = 1'b0;
        wait_cyc(130);
        chk("ur_zero_frame", word_at(base, 1'b0), 32'h0);
        chk("ur_held", 32'(underrun), 32'd1);
        clr_underrun = 1'b1;
        wait_cyc(1);
        clr_underrun = 1'b0;
        chk("ur_cleared", 32'(underrun), 32'd0);

        // Backpressure: four pairs fill the FIFO, the fifth waits for the first pop.
        for (int i = 0; i < 4; i++) push_pair(tl[i], tr[i]);
        chk("bp_full_level", 32'(fifo_level), 32'd4);
        chk("bp_full_ready", 32'(s_if.s_ready), 32'd0);
        s_if.s_valid = 1'b1;
        s_if.s_left = tl[4];
        s_if.s_right = tr[4];
        base = n_cap;
        en = 1'b1;
        b = 0;
        while (!s_if.s_ready && b < 300) begin
            @(negedge clk);
            b++;
        end
        chk("bp_ready_rise", 32'(s_if.s_ready), 32'd1);
        chk("bp_level_after_pop", 32'(fifo_level), 32'd3);
        @(negedge clk);
        s_if.s_valid = 1'b0;
        chk("bp_level_after_push", 32'(fifo_level), 32'd4);
        wait_cyc(4 * FCYC);
        en = 1'b0;
        wait_cyc(140);
        chk("bp_nbits", 32'(n_cap - base), 32'd160);
        for (int i = 0; i < 5; i++) chk("bp_frame", word_at(base + 32 * i, 1'b0), {tl[i], tr[i]});
        chk("bp_empty", 32'(fifo_level), 32'd0);
        chk("bp_no_underrun", 32'(underrun), 32'd0);

        // Mid-frame reset with data buffered and underrun set.
        en = 1'b1;
        wait_cyc(3);
        push_pair(16'hBEEF, 16'hCAFE);
        wait_cyc(40);
        chk("pre_rst_underrun", 32'(underrun), 32'd1);
        chk("pre_rst_level", 32'(fifo_level), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        en = 1'b0;
        @(negedge clk);
        chk("mrst_sclk", 32'(sclk), 32'd0);
        chk("mrst_ws", 32'(ws), 32'd0);
        chk("mrst_sd", 32'(sd), 32'd0);
        chk("mrst_level", 32'(fifo_level), 32'd0);
        chk("mrst_underrun", 32'(underrun), 32'd0);
        rst = 1'b1;
        wait_cyc(3);
        chk("mrst_ready", 32'(s_if.s_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule
